// File: rtl/vmx_pkg.sv
// vmx_pkg: shared constants, FSM states and status codes for the VMX requantizer
package vmx_pkg;
    localparam int ACC_W = 32;
    localparam int Q_W = 16;
    localparam int LANES = 4;
    localparam int ADDR_W = 8;
    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR, DONE} state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD = 2'd1;
    localparam logic [1:0] ST_WR = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/vmx_requant_lane.sv
// vmx_requant_lane: combinational relu, round-half-up arithmetic shift and int16 saturation
module vmx_requant_lane
    import vmx_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [4:0]       sh,
    input  logic             relu_en,
    output logic [Q_W-1:0]   q,
    output logic             sat
);
    // one guard bit keeps acc + 2^(sh-1) from wrapping near INT32_MAX
    logic signed [ACC_W:0] x, rnd, y;
    logic hi, lo;
    always_comb begin
        x = (relu_en && acc[ACC_W-1]) ? '0 : $signed({acc[ACC_W-1], acc});
        rnd = (sh == 5'd0) ? '0 : 33'sd1 <<< (sh - 5'd1);
        y = (x + rnd) >>> sh;
        hi = y > 33'sd32767;
        lo = y < -33'sd32768;
        q = hi ? 16'h7FFF : lo ? 16'h8000 : y[Q_W-1:0];
        sat = hi | lo;
    end
endmodule

// File: rtl/vmx_requant.sv
// vmx_requant: reads 4x4 int32 accumulators from the local buffer, requantizes to int16
// and writes packed rows back, three cycles per row.
module vmx_requant
    import vmx_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SRC_BASE = 8'h08,
    parameter logic [ADDR_W-1:0] DST_BASE = 8'h10,
    parameter int                ROWS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ctrl,
    output logic [ADDR_W-1:0] addr,
    input  logic [63:0]       d_i,
    output logic              wr_en,
    output logic [63:0]       d_o,
    output logic [31:0]       flag
);
    state_t state, state_n;
    logic prev, start, relu_en, last;
    logic [4:0] sh, sat_cnt;
    logic [ADDR_W-1:0] row;
    logic [ACC_W-1:0] acc [LANES];
    logic [Q_W-1:0] q [LANES];
    logic [LANES-1:0] sat;
    logic [2:0] nsat;
    logic [1:0] status;
    logic unused_ctrl;

    assign unused_ctrl = ^ctrl[31:7];
    assign start = ctrl[0] & ~prev;
    assign last = row == ADDR_W'(ROWS - 1);
    assign nsat = 3'(sat[0]) + 3'(sat[1]) + 3'(sat[2]) + 3'(sat[3]);
    assign d_o = {q[0], q[1], q[2], q[3]};
    assign flag = {16'h0, 3'b0, sat_cnt, 6'b0, status};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vmx_requant_lane u_lane (
            .acc(acc[i]),
            .sh(sh),
            .relu_en(relu_en),
            .q(q[i]),
            .sat(sat[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        addr = '0;
        wr_en = 1'b0;
        status = ST_IDLE;
        unique case (state)
            IDLE: state_n = start ? RD_HI : IDLE;
            RD_HI: begin
                addr = SRC_BASE + (row << 1);
                status = ST_RD;
                state_n = RD_LO;
            end
            RD_LO: begin
                addr = SRC_BASE + (row << 1) + ADDR_W'(1);
                status = ST_RD;
                state_n = WR;
            end
            WR: begin
                addr = DST_BASE + row;
                wr_en = 1'b1;
                status = ST_WR;
                state_n = last ? DONE : RD_HI;
            end
            DONE: begin
                addr = DST_BASE + row;
                status = ST_DONE;
                state_n = start ? RD_HI : DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            row <= '0;
            sh <= '0;
            relu_en <= 1'b0;
            sat_cnt <= '0;
            acc <= '{default: '0};
        end else begin
            prev <= ctrl[0];
            if (start && (state == IDLE || state == DONE)) begin
                sh <= ctrl[5:1];
                relu_en <= ctrl[6];
                row <= '0;
                sat_cnt <= '0;
            end
            if (state == RD_HI) begin
                acc[0] <= d_i[63:32];
                acc[1] <= d_i[31:0];
            end
            if (state == RD_LO) begin
                acc[2] <= d_i[63:32];
                acc[3] <= d_i[31:0];
            end
            if (state == WR) begin
                sat_cnt <= sat_cnt + 5'(nsat);
                if (!last) row <= row + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vmx_requant.sv
// tb_vmx_requant: directed vectors against a buffer model; expected writes are
// queued at stimulus time and popped by an independent write monitor.
module tb_vmx_requant;
    import vmx_pkg::*;
    localparam logic [7:0] SRC = 8'h08;
    localparam logic [7:0] DST = 8'h10;
    localparam logic [63:0] SENT = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] ctrl = '0;
    logic [7:0] addr;
    logic [63:0] d_i, d_o;
    logic wr_en;
    logic [31:0] flag;
    logic [63:0] mem [256];
    logic [71:0] sb [$];
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    vmx_requant dut (
        .clk(clk),
        .rst(rst),
        .ctrl(ctrl),
        .addr(addr),
        .d_i(d_i),
        .wr_en(wr_en),
        .d_o(d_o),
        .flag(flag)
    );

    always #5 clk = ~clk;
    assign d_i = mem[addr];
    always @(posedge clk) if (wr_en) mem[addr] = d_o;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr got=%h_%h want=none", addr, d_o);
            end else chk("wr", {addr, d_o}, sb.pop_front());
        end
    end

    task automatic set_row(input int r, input logic [31:0] l0, l1, l2, l3);
        mem[SRC + 8'(2 * r)] = {l0, l1};
        mem[SRC + 8'(2 * r + 1)] = {l2, l3};
    endtask

    task automatic exp_row(input int r, input logic [63:0] d);
        sb.push_back({DST + 8'(r), d});
    endtask

    task automatic load_identity();
        set_row(0, 32'd1, 32'd0, 32'd0, 32'd0);
        set_row(1, 32'd0, 32'd1, 32'd0, 32'd0);
        set_row(2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
        set_row(3, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    endtask

    task automatic exp_identity();
        exp_row(0, 64'h0001_0000_0000_0000);
        exp_row(1, 64'h0000_0001_0000_0000);
        exp_row(2, 64'h0000_0000_FFFF_0000);
        exp_row(3, 64'h0000_0000_0000_FFFF);
    endtask

    // leaves the bench at the negedge of the first RD_HI cycle when hold == 1
    task automatic start_run(input logic [4:0] sh, input logic relu, input int hold);
        wr_cnt = 0;
        @(negedge clk);
        ctrl = {25'h0, relu, sh, 1'b1};
        repeat (hold) @(negedge clk);
        ctrl[0] = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (flag[1:0] != ST_DONE && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 72'(flag[1:0]), 72'(ST_DONE));
        chk({name, "_queue"}, 72'(sb.size()), 72'd0);
        chk({name, "_wr_pulses"}, 72'(wr_cnt), 72'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_addr", 72'(addr), 72'h0);
        chk("rst_wr_en", 72'(wr_en), 72'h0);
        chk("rst_d_o", 72'(d_o), 72'h0);
        chk("rst_flag", 72'(flag), 72'h0);
        rst = 1'b0;

        load_identity();
        exp_identity();
        start_run(5'd0, 1'b0, 1);
        chk("id_c1_flag", 72'(flag), 72'h1);
        chk("id_c1_addr", 72'(addr), 72'(SRC));
        repeat (11) @(negedge clk);
        chk("id_c12_flag", 72'(flag[1:0]), 72'(ST_WR));
        chk("id_c12_addr", 72'(addr), 72'(DST + 8'd3));
        @(negedge clk);
        chk("id_c13_flag", 72'(flag), 72'h3);
        wait_done("id");
        repeat (3) @(negedge clk);
        chk("done_hold_addr", 72'(addr), 72'(DST + 8'd3));
        chk("done_hold_d_o", 72'(d_o), 72'h0000_0000_0000_FFFF);
        chk("done_hold_wr_en", 72'(wr_en), 72'h0);

        exp_row(0, 64'h0001_0000_0000_0000);
        exp_row(1, 64'h0000_0001_0000_0000);
        exp_row(2, 64'h0);
        exp_row(3, 64'h0);
        start_run(5'd0, 1'b1, 1);
        wait_done("relu");

        set_row(0, 32'd6, 32'hFFFF_FFFA, 32'd5, 32'd7);
        set_row(1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h100, 32'hFFFF_FFFE);
        set_row(2, 32'd0, 32'd0, 32'd0, 32'd0);
        set_row(3, 32'd0, 32'd0, 32'd0, 32'd0);
        exp_row(0, 64'h0002_FFFF_0001_0002);
        exp_row(1, 64'hFFFE_0000_0040_0000);
        exp_row(2, 64'h0);
        exp_row(3, 64'h0);
        start_run(5'd2, 1'b0, 1);
        wait_done("round");
        chk("round_sat", 72'(flag[15:8]), 72'h0);

        set_row(0, 32'h0001_0000, 32'h8000_0000, 32'h0000_7FFF, 32'hFFFF_8000);
        set_row(1, 32'd0, 32'd0, 32'd0, 32'd0);
        exp_row(0, 64'h7FFF_8000_7FFF_8000);
        exp_row(1, 64'h0);
        exp_row(2, 64'h0);
        exp_row(3, 64'h0);
        start_run(5'd0, 1'b0, 1);
        wait_done("sat0");
        chk("sat0_flag", 72'(flag), 72'h0203);

        set_row(0, 32'h7FFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0001, 32'd3);
        exp_row(0, 64'h7FFF_7FFF_8001_0002);
        exp_row(1, 64'h0);
        exp_row(2, 64'h0);
        exp_row(3, 64'h0);
        start_run(5'd1, 1'b0, 1);
        chk("restart_clears_sat", 72'(flag), 72'h1);
        wait_done("sat1");
        chk("sat1_flag", 72'(flag), 72'h0203);

        load_identity();
        exp_identity();
        start_run(5'd0, 1'b0, 1);
        @(negedge clk);
        chk("glitch_in_rd_lo", 72'(flag[1:0]), 72'(ST_RD));
        ctrl[0] = 1'b1;
        @(negedge clk);
        ctrl[0] = 1'b0;
        wait_done("glitch");

        exp_identity();
        start_run(5'd0, 1'b0, 3);
        wait_done("held");
        repeat (5) @(negedge clk);
        chk("held_stays_done", 72'(flag[1:0]), 72'(ST_DONE));
        chk("held_wr_pulses", 72'(wr_cnt), 72'd4);

        for (int r = 0; r < 4; r++) mem[DST + 8'(r)] = SENT;
        exp_row(0, 64'h0001_0000_0000_0000);
        exp_row(1, 64'h0000_0001_0000_0000);
        start_run(5'd0, 1'b0, 1);
        repeat (5) @(negedge clk);
        chk("abort_in_wr1", 72'(flag[1:0]), 72'(ST_WR));
        chk("abort_addr_wr1", 72'(addr), 72'(DST + 8'd1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", 72'(wr_en), 72'h0);
        chk("abort_flag", 72'(flag), 72'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_idle", 72'(flag), 72'h0);
        chk("abort_row1", 72'(mem[DST + 8'd1]), 72'h0000_0001_0000_0000);
        chk("abort_row2", 72'(mem[DST + 8'd2]), 72'(SENT));
        chk("abort_row3", 72'(mem[DST + 8'd3]), 72'(SENT));
        chk("abort_queue", 72'(sb.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
